// File: rtl/multicycle_dispatch_pkg.sv
// Shared types and constants for the multi-cycle unit dispatcher.
package multicycle_dispatch_pkg;

  localparam int mcu_num_units = 2;
  localparam int mcu_xlen      = 32;
  localparam int mcu_op_w      = 4;

  localparam int unit_div = 0;
  localparam int unit_mul = 1;

  // Index width for a given unit count, never narrower than one bit.
  function automatic int mcu_unit_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int mcu_unit_w = mcu_unit_width(mcu_num_units);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mcu_state_type;

  typedef struct packed {
    logic                              issue_valid;
    logic [mcu_unit_w-1:0]             issue_unit;
    logic [mcu_op_w-1:0]               issue_op;
    logic [mcu_xlen-1:0]               issue_rdata1;
    logic [mcu_xlen-1:0]               issue_rdata2;
    logic [4:0]                        issue_waddr;
    logic                              hold;
    logic                              clear;
    logic [mcu_num_units-1:0]          unit_ready;
    logic [mcu_num_units*mcu_xlen-1:0] unit_result;
  } multicycle_dispatch_in_type;

  typedef struct packed {
    logic [mcu_num_units-1:0] unit_enable;
    logic [mcu_op_w-1:0]      unit_op;
    logic [mcu_xlen-1:0]      unit_rdata1;
    logic [mcu_xlen-1:0]      unit_rdata2;
    logic                     stall;
    logic                     done;
    logic [mcu_xlen-1:0]      result;
    logic                     wren;
    logic [4:0]               waddr;
    logic                     illegal;
  } multicycle_dispatch_out_type;

endpackage

// File: rtl/multicycle_dispatch.sv
// Dispatcher between execute and NUM_UNITS multi-cycle units: start pulse, tracking, stall, result hold.
// Optional MCU_BYPASS_EN forwards unit_result straight to writeback in the ready cycle.
module multicycle_dispatch
  import multicycle_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = mcu_num_units,
  parameter int XLEN      = mcu_xlen,
  parameter int OP_W      = mcu_op_w,
  parameter int UNIT_W    = mcu_unit_width(NUM_UNITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [UNIT_W-1:0]         issue_unit,
  input  logic [OP_W-1:0]           issue_op,
  input  logic [XLEN-1:0]           issue_rdata1,
  input  logic [XLEN-1:0]           issue_rdata2,
  input  logic [4:0]                issue_waddr,
  input  logic                      hold,
  input  logic                      clear,
  output logic [NUM_UNITS-1:0]      unit_enable,
  output logic [OP_W-1:0]           unit_op,
  output logic [XLEN-1:0]           unit_rdata1,
  output logic [XLEN-1:0]           unit_rdata2,
  input  logic [NUM_UNITS-1:0]      unit_ready,
  input  logic [NUM_UNITS*XLEN-1:0] unit_result,
  output logic                      stall,
  output logic                      done,
  output logic [XLEN-1:0]           result,
  output logic                      wren,
  output logic [4:0]                waddr,
  output logic                      illegal
);

  mcu_state_type         state_r, state_s;
  logic [UNIT_W-1:0]     idx_r;
  logic [4:0]            waddr_r;
  logic [XLEN-1:0]       result_r;

  logic                  legal_s;
  logic                  sel_ready_s;
  logic [XLEN-1:0]       sel_result_s;
  logic                  accept_s;
  logic                  capture_s;
  logic                  done_s;
  logic                  illegal_s;
  logic [XLEN-1:0]       result_s;
  logic [NUM_UNITS-1:0]  enable_s;

  assign legal_s = (32'(issue_unit) < 32'(NUM_UNITS));

  // Pick the latched unit's strobe and result; other units' strobes never reach the FSM.
  always_comb begin
    sel_ready_s  = 1'b0;
    sel_result_s = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sel_ready_s  = sel_ready_s | ((idx_r == UNIT_W'(i)) & unit_ready[i]);
      sel_result_s = sel_result_s | ({XLEN{idx_r == UNIT_W'(i)}} & unit_result[i*XLEN +: XLEN]);
    end
  end

  // One-hot start pulse for the accepted issue.
  always_comb begin
    enable_s = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      enable_s[i] = accept_s & (issue_unit == UNIT_W'(i));
    end
  end

  // Next-state and writeback decode.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    done_s    = 1'b0;
    illegal_s = 1'b0;
    result_s  = '0;
    case (state_r)
      IDLE: begin
        if (issue_valid & ~clear) begin
          if (~legal_s) begin
            illegal_s = 1'b1;
            done_s    = 1'b1;
          end else if (~hold) begin
            accept_s = 1'b1;
            state_s  = BUSY;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (sel_ready_s) begin
          if (clear) begin
            state_s = IDLE;
          end else begin
`ifdef MCU_BYPASS_EN
            done_s   = 1'b1;
            result_s = sel_result_s;
            if (hold) begin
              capture_s = 1'b1;
              state_s   = DONE;
            end else begin
              state_s = IDLE;
            end
`else
            capture_s = 1'b1;
            state_s   = DONE;
`endif
          end
        end else if (clear) begin
          state_s = DRAIN;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (clear) begin
          state_s = IDLE;
        end else begin
          done_s   = 1'b1;
          result_s = result_r;
          state_s  = hold ? DONE : IDLE;
        end
      end
      DRAIN: begin
        if (sel_ready_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and latched-operation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      waddr_r  <= 5'd0;
      result_r <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        idx_r   <= issue_unit;
        waddr_r <= issue_waddr;
      end
      if (capture_s) begin
        result_r <= sel_result_s;
      end
    end
  end

  assign unit_op     = issue_op;
  assign unit_rdata1 = issue_rdata1;
  assign unit_rdata2 = issue_rdata2;

  // Reset forces the writeback/stall side quiet even while issue inputs are still driven.
  assign unit_enable = rst ? '0 : enable_s;
  assign done        = ~rst & done_s;
  assign illegal     = ~rst & illegal_s;
  assign stall       = ~rst & issue_valid & ~clear & ~done_s;
  assign result      = rst ? '0 : result_s;
  assign waddr       = rst ? 5'd0 : waddr_r;
  assign wren        = done & ~illegal_s & (waddr_r != 5'd0);

endmodule
